// File: rtl/memory_stage.sv
// memory_stage -- MEM stage of the five-stage RV32 pipeline.
//
// Takes the EX/MEM pipeline outputs, runs the load/store access to data memory
// over a req/ready handshake (byte lanes, sign/zero extension), issues the
// branch redirect, stalls upstream while memory is busy, and registers results
// into the MEM/WB pipeline register.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   strCtrlM[2:0]               access size/sign (RV32 funct3; 011/110/111 act as W)
//   RegWriteM, MemWriteM,
//   MemtoRegM                   EX/MEM control
//   PCBranchM, branchM          branch instruction flag, condition taken
//   ALUoutM, PCplusImmM, r2M    address/ALU result, branch target, store data
//   rdM[4:0]                    destination register
//   PCSrcM, PCTargetM           branch redirect (combinational)
//   stallM                      freeze IF..EX/MEM this cycle
//   dmem_req/we/addr/wdata/be   data memory request side
//   dmem_rdata, dmem_ready      data memory response side
//   RegWriteW, MemtoRegW,
//   ALUoutW, ReadDataW, rdW,
//   misalignW                   MEM/WB pipeline register outputs
//
// Build option: define MISALIGN_TRAP_EN to flag misaligned H/W accesses
// (no request is issued, misalignW is set, register write suppressed).
// Without it misalignW is tied 0 and low address bits are ignored for H/W.
`timescale 1ns/1ps

module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  strCtrlM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        PCBranchM,
  input  logic        branchM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] PCplusImmM,
  input  logic [31:0] r2M,
  input  logic [4:0]  rdM,
  output logic        PCSrcM,
  output logic [31:0] PCTargetM,
  output logic        stallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  rdW,
  output logic        misalignW
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        mem_op, is_load, access, misalign;
  logic        size_b, size_h, load_unsigned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Size decode: funct3[1:0] 00 -> byte, 01 -> half, anything else -> word.
  assign size_b        = (strCtrlM[1:0] == 2'b00);
  assign size_h        = (strCtrlM[1:0] == 2'b01);
  assign load_unsigned = strCtrlM[2];

  assign mem_op  = MemWriteM | MemtoRegM;
  // Store wins when both are set, so only a pure load captures read data.
  assign is_load = MemtoRegM & ~MemWriteM;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      if (size_h)
        misalign = ALUoutM[0];
      else if (!size_b)
        misalign = (ALUoutM[1:0] != 2'b00);
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign access = mem_op & ~misalign;

  // Branch redirect is independent of the memory handshake.
  assign PCSrcM    = PCBranchM & branchM;
  assign PCTargetM = PCplusImmM;

  // Request and stall are gated by rst so they drop the moment reset asserts.
  // Upstream holds inputs while stalled, so access stays high through WAIT.
  assign dmem_req  = access & ~rst;
  assign stallM    = dmem_req & ~dmem_ready;
  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUoutM[31:2], 2'b00};

  // Store lane replication and byte enables.
  always_comb begin
    dmem_wdata = r2M;
    dmem_be    = 4'b1111;
    if (size_b) begin
      dmem_wdata = {4{r2M[7:0]}};
      dmem_be    = 4'b0001 << ALUoutM[1:0];
    end else if (size_h) begin
      dmem_wdata = {2{r2M[15:0]}};
      dmem_be    = 4'b0011 << {ALUoutM[1], 1'b0};
    end
  end

  // Load lane extraction and sign/zero extension.
  assign byte_sel = dmem_rdata[{ALUoutM[1:0], 3'b000} +: 8];
  assign half_sel = ALUoutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    if (size_b)
      load_ext = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
    else if (size_h)
      load_ext = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
    else
      load_ext = dmem_rdata;
  end

  // Handshake FSM: WAIT is entered only when an issued access is not ready.
  always_comb begin
    state_d = S_IDLE;
    if (access && !dmem_ready)
      state_d = S_WAIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // MEM/WB register. A stalled edge inserts a bubble (no write, no load
  // select) while the data fields hold their previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ALUoutW   <= 32'h0;
      ReadDataW <= 32'h0;
      rdW       <= 5'h0;
    end else if (stallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~misalign;
      MemtoRegW <= MemtoRegM;
      ALUoutW   <= ALUoutM;
      ReadDataW <= (is_load && access) ? load_ext : 32'h0;
      rdW       <= rdM;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_q <= 1'b0;
    else if (!stallM)
      misalign_q <= misalign;
  end

  assign misalignW = misalign_q;
`else
  assign misalignW = 1'b0;
`endif

endmodule
